mem_stage: RTL

- Memory-access pipeline stage between the EX/MEM latch and writeback.
- Converts RV32I load/store micro-ops into requests on the memory controller's data port: mm_e, mm_a, mm_n_i, mm_wr and mm_cu out; mm_ok and mm_n_o back.
- Waits for the controller's ok/release handshake, then sign- or zero-extends load data.
- Presents one result per instruction to writeback and stalls upstream while a memory access is outstanding.

---
 rtl/mem_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: turns RV32I load/store micro-ops into ok/release
// handshakes on the memory controller's data port and formats results for writeback.
//
// state | meaning
// IDLE  | ready for a micro-op; non-memory ops complete here in one cycle
// REQ   | mm_e high and request held stable until the controller returns mm_ok
// REL   | request dropped; waiting for mm_ok to fall before taking another op
module mem_stage #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic          ex_ld,
    input  logic          ex_st,
    input  logic [2:0]    ex_f3,
    input  logic [AW-1:0] ex_addr,
    input  logic [31:0]   ex_wdata,
    input  logic [4:0]    ex_rd,
    input  logic [31:0]   ex_res,

    output logic          mm_e,
    output logic [AW-1:0] mm_a,
    output logic [31:0]   mm_n_i,
    output logic          mm_wr,
    output logic [1:0]    mm_cu,
    input  logic          mm_ok,
    input  logic [31:0]   mm_n_o,

    output logic          wb_valid,
    output logic [4:0]    wb_rd,
    output logic [31:0]   wb_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  rd_q;
    logic [2:0]  f3_q;
    logic [1:0]  cu_next;
    logic [31:0] ld_data;

    assign ex_ready = (state == IDLE);

    // Size 11 is not a legal RV32I width; it is issued as a word access.
    always_comb begin
        cu_next = 2'd3;
        case (ex_f3[1:0])
            2'b00:   cu_next = 2'd0;
            2'b01:   cu_next = 2'd1;
            default: cu_next = 2'd3;
        endcase
    end

    // The controller already zero-extends to the access size; only signed
    // byte/half loads need the upper bits filled.
    always_comb begin
        ld_data = mm_n_o;
        case (f3_q)
            3'b000:  ld_data = {{24{mm_n_o[7]}}, mm_n_o[7:0]};
            3'b001:  ld_data = {{16{mm_n_o[15]}}, mm_n_o[15:0]};
            3'b100:  ld_data = {24'd0, mm_n_o[7:0]};
            3'b101:  ld_data = {16'd0, mm_n_o[15:0]};
            default: ld_data = mm_n_o;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mm_e     <= 1'b0;
            mm_a     <= '0;
            mm_n_i   <= 32'd0;
            mm_wr    <= 1'b0;
            mm_cu    <= 2'd0;
            rd_q     <= 5'd0;
            f3_q     <= 3'd0;
            wb_valid <= 1'b0;
            wb_rd    <= 5'd0;
            wb_data  <= 32'd0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (ex_ld || ex_st) begin
                            mm_a   <= ex_addr;
                            mm_wr  <= ex_st;
                            mm_n_i <= ex_wdata;
                            mm_cu  <= cu_next;
                            rd_q   <= ex_rd;
                            f3_q   <= ex_f3;
                            mm_e   <= 1'b1;
                            state  <= REQ;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_rd    <= ex_rd;
                            wb_data  <= ex_res;
                        end
                    end
                end
                REQ: begin
                    if (mm_ok) begin
                        mm_e     <= 1'b0;
                        wb_valid <= 1'b1;
                        if (mm_wr) begin
                            wb_rd   <= 5'd0;
                            wb_data <= 32'd0;
                        end else begin
                            wb_rd   <= rd_q;
                            wb_data <= ld_data;
                        end
                        state <= REL;
                    end
                end
                REL: begin
                    if (!mm_ok) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    mm_e  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
